// File: rtl/pc_fetch_sequencer.sv
// Program counter owner and instruction fetch sequencer: issues imem req/ack
// fetches, latches the returned word and presents it to decode via valid/ready.
module pc_fetch_sequencer #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned STEP     = 2,
    parameter int unsigned RESET_PC = 0
) (
    input  logic             clock,
    input  logic             reset_n,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] imem_data,
    output logic [WIDTH-1:0] instr,
    output logic             instr_valid,
    input  logic             instr_ready,
    input  logic             stall,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        FLUSH = 2'd2
    } state_e;

    state_e           state, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] instr_q, instr_d;
    logic [WIDTH-1:0] stale_q, stale_d;
    logic             valid_q, valid_d;

    // Next-state and datapath update; redirect outranks stall and acceptance.
    always_comb begin
        state_d = state;
        pc_d    = pc_q;
        instr_d = instr_q;
        stale_d = stale_q;
        unique case (state)
            FETCH: begin
                if (redirect) begin
                    pc_d = redirect_pc;
                    if (!imem_ack) begin
                        stale_d = pc_q;
                        state_d = FLUSH;
                    end
                end else if (imem_ack) begin
                    instr_d = imem_data;
                    state_d = HOLD;
                end
            end
            FLUSH: begin
                // Keep requesting the abandoned address until memory completes it.
                if (redirect) begin
                    pc_d = redirect_pc;
                end
                if (imem_ack) begin
                    state_d = FETCH;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_d    = redirect_pc;
                    state_d = FETCH;
                end else if (!stall && instr_ready) begin
                    pc_d    = pc_q + WIDTH'(STEP);
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
        valid_d = (state_d == HOLD);
    end

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= FETCH;
            pc_q    <= WIDTH'(RESET_PC);
            instr_q <= '0;
            stale_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            stale_q <= stale_d;
            valid_q <= valid_d;
        end
    end

    // Request is masked while reset is held so nothing issues before release.
    assign imem_req    = reset_n && (state != HOLD);
    assign imem_addr   = (state == FLUSH) ? stale_q : pc_q;
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign pc          = pc_q;
    assign pc_plus     = pc_q + WIDTH'(STEP);

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed vector bench for pc_fetch_sequencer: per-cycle input records with
// hand-computed expected outputs, plus pending-fetch and async-reset sequences.
module tb_pc_fetch_sequencer;

    localparam int unsigned W = 16;

    typedef struct {
        logic         ready;
        logic         stall;
        logic         redir;
        logic [W-1:0] rpc;
        logic         ack;
        logic [W-1:0] data;
        logic         e_req;
        logic [W-1:0] e_addr;
        logic         e_valid;
        logic [W-1:0] e_instr;
        logic [W-1:0] e_pc;
    } vec_t;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         imem_req;
    logic [W-1:0] imem_addr;
    logic         imem_ack = 1'b0;
    logic [W-1:0] imem_data = '0;
    logic [W-1:0] instr;
    logic         instr_valid;
    logic         instr_ready = 1'b0;
    logic         stall = 1'b0;
    logic         redirect = 1'b0;
    logic [W-1:0] redirect_pc = '0;
    logic [W-1:0] pc;
    logic [W-1:0] pc_plus;

    int errors = 0;
    int checks = 0;

    pc_fetch_sequencer #(.WIDTH(W), .STEP(2), .RESET_PC(0)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_data   (imem_data),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .pc          (pc),
        .pc_plus     (pc_plus)
    );

    always #5 clock = ~clock;

    function automatic vec_t mk(input logic rd, input logic st, input logic rr,
                                input logic [W-1:0] rp, input logic ak,
                                input logic [W-1:0] dt, input logic q,
                                input logic [W-1:0] a, input logic v,
                                input logic [W-1:0] ins, input logic [W-1:0] p);
        vec_t r;
        r.ready = rd; r.stall = st; r.redir = rr; r.rpc = rp; r.ack = ak;
        r.data = dt; r.e_req = q; r.e_addr = a; r.e_valid = v;
        r.e_instr = ins; r.e_pc = p;
        return r;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one record, clock it in, then compare outputs just after the edge.
    task automatic step(input string tag, input vec_t v);
        instr_ready = v.ready;
        stall       = v.stall;
        redirect    = v.redir;
        redirect_pc = v.rpc;
        imem_ack    = v.ack;
        imem_data   = v.data;
        @(posedge clock);
        #1;
        check({tag, " req"},     W'(imem_req),    W'(v.e_req));
        check({tag, " addr"},    imem_addr,       v.e_addr);
        check({tag, " valid"},   W'(instr_valid), W'(v.e_valid));
        check({tag, " instr"},   instr,           v.e_instr);
        check({tag, " pc"},      pc,              v.e_pc);
        check({tag, " pc_plus"}, pc_plus,         v.e_pc + W'(2));
    endtask

    vec_t vecs[27];
    vec_t seq[8];

    initial begin
        // ready stall redir rpc ack data | req addr valid instr pc
        vecs[0]  = mk(1,0,0,16'h0000,1,16'hA5A5, 0,16'h0000,1,16'hA5A5,16'h0000);
        vecs[1]  = mk(1,0,0,16'h0000,0,16'h0000, 1,16'h0002,0,16'hA5A5,16'h0002);
        vecs[2]  = mk(1,0,0,16'h0000,1,16'hA5A7, 0,16'h0002,1,16'hA5A7,16'h0002);
        vecs[3]  = mk(1,0,0,16'h0000,0,16'h0000, 1,16'h0004,0,16'hA5A7,16'h0004);
        vecs[4]  = mk(1,0,0,16'h0000,1,16'hA5A1, 0,16'h0004,1,16'hA5A1,16'h0004);
        vecs[5]  = mk(1,0,0,16'h0000,0,16'h0000, 1,16'h0006,0,16'hA5A1,16'h0006);
        vecs[6]  = mk(1,0,0,16'h0000,1,16'hA5A3, 0,16'h0006,1,16'hA5A3,16'h0006);
        vecs[7]  = mk(1,0,1,16'h0010,0,16'h0000, 1,16'h0010,0,16'hA5A3,16'h0010);
        vecs[8]  = mk(1,0,0,16'h0000,1,16'h1234, 0,16'h0010,1,16'h1234,16'h0010);
        vecs[9]  = mk(1,1,0,16'h0000,0,16'h0000, 0,16'h0010,1,16'h1234,16'h0010);
        vecs[10] = mk(1,1,0,16'h0000,0,16'h0000, 0,16'h0010,1,16'h1234,16'h0010);
        vecs[11] = mk(1,1,0,16'h0000,0,16'h0000, 0,16'h0010,1,16'h1234,16'h0010);
        vecs[12] = mk(1,0,0,16'h0000,0,16'h0000, 1,16'h0012,0,16'h1234,16'h0012);
        vecs[13] = mk(0,0,1,16'h0020,0,16'h0000, 1,16'h0012,0,16'h1234,16'h0020);
        vecs[14] = mk(0,0,0,16'h0000,1,16'hDEAD, 1,16'h0020,0,16'h1234,16'h0020);
        vecs[15] = mk(0,0,0,16'h0000,1,16'h2020, 0,16'h0020,1,16'h2020,16'h0020);
        vecs[16] = mk(0,1,1,16'h0100,0,16'h0000, 1,16'h0100,0,16'h2020,16'h0100);
        vecs[17] = mk(0,0,1,16'h0040,1,16'hBAD1, 1,16'h0040,0,16'h2020,16'h0040);
        vecs[18] = mk(0,0,0,16'h0000,1,16'h4040, 0,16'h0040,1,16'h4040,16'h0040);
        vecs[19] = mk(1,0,0,16'h0000,0,16'h0000, 1,16'h0042,0,16'h4040,16'h0042);
        vecs[20] = mk(0,0,1,16'h0300,0,16'h0000, 1,16'h0042,0,16'h4040,16'h0300);
        vecs[21] = mk(0,0,1,16'h0400,1,16'hBAD2, 1,16'h0400,0,16'h4040,16'h0400);
        vecs[22] = mk(0,0,0,16'h0000,1,16'h4444, 0,16'h0400,1,16'h4444,16'h0400);
        vecs[23] = mk(0,0,0,16'h0000,0,16'h0000, 0,16'h0400,1,16'h4444,16'h0400);
        vecs[24] = mk(0,0,1,16'hFFFE,0,16'h0000, 1,16'hFFFE,0,16'h4444,16'hFFFE);
        vecs[25] = mk(0,0,0,16'h0000,1,16'h7777, 0,16'hFFFE,1,16'h7777,16'hFFFE);
        vecs[26] = mk(1,0,0,16'h0000,0,16'h0000, 1,16'h0000,0,16'h7777,16'h0000);

        // Slow memory: req at 0x0030, redirect to 0x0200 while it is outstanding.
        seq[0] = mk(0,0,1,16'h0030,1,16'hBAD4, 1,16'h0030,0,16'h7777,16'h0030);
        seq[1] = mk(0,0,0,16'h0000,0,16'h0000, 1,16'h0030,0,16'h7777,16'h0030);
        seq[2] = mk(0,0,1,16'h0200,0,16'h0000, 1,16'h0030,0,16'h7777,16'h0200);
        seq[3] = mk(0,0,0,16'h0000,0,16'h0000, 1,16'h0030,0,16'h7777,16'h0200);
        seq[4] = mk(0,0,0,16'h0000,1,16'hBAD3, 1,16'h0200,0,16'h7777,16'h0200);
        seq[5] = mk(0,0,0,16'h0000,1,16'hA7A5, 0,16'h0200,1,16'hA7A5,16'h0200);
        seq[6] = mk(0,0,1,16'h0500,0,16'h0000, 1,16'h0500,0,16'hA7A5,16'h0500);
        seq[7] = mk(0,0,1,16'h0600,0,16'h0000, 1,16'h0500,0,16'hA7A5,16'h0600);

        repeat (2) @(posedge clock);
        #1;
        check("rst req",   W'(imem_req),    W'(1'b0));
        check("rst valid", W'(instr_valid), W'(1'b0));
        check("rst pc",    pc,              16'h0000);
        check("rst instr", instr,           16'h0000);
        reset_n = 1'b1;
        #1;
        check("rel req",  W'(imem_req), W'(1'b1));
        check("rel addr", imem_addr,     16'h0000);

        for (int i = 0; i < 27; i++) begin
            step($sformatf("v%0d", i), vecs[i]);
        end
        for (int i = 0; i < 8; i++) begin
            step($sformatf("s%0d", i), seq[i]);
        end

        // Now in FLUSH at stale 0x0500; reset between edges with an ack pending.
        redirect  = 1'b0;
        imem_ack  = 1'b1;
        imem_data = 16'hBAD5;
        #3;
        reset_n = 1'b0;
        #1;
        check("arst req",   W'(imem_req),    W'(1'b0));
        check("arst valid", W'(instr_valid), W'(1'b0));
        check("arst pc",    pc,              16'h0000);
        check("arst instr", instr,           16'h0000);
        @(posedge clock);
        #1;
        check("arst hold req", W'(imem_req), W'(1'b0));
        imem_ack = 1'b0;
        reset_n  = 1'b1;
        #1;
        check("arst rel req",  W'(imem_req), W'(1'b1));
        check("arst rel addr", imem_addr,     16'h0000);
        step("post", mk(1,0,0,16'h0000,1,16'hA5A5, 0,16'h0000,1,16'hA5A5,16'h0000));
        step("post2", mk(1,0,0,16'h0000,0,16'h0000, 1,16'h0002,0,16'hA5A5,16'h0002));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
